mmu_xram_pp: RTL and testbench



---
 rtl/mmu_xram_pp.sv | 141 ++++++++++++++
 tb/tb_mmu_xram_pp.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mmu_xram_pp.sv
// Ping-pong serial-to-parallel image buffer: CORE_N-element words in, KSIZE-element kernel rows out.
// Define MMU_XRAM_ZPAD_EN to zero lanes/rows beyond the committed word count on reads.
module mmu_xram_pp #(
  parameter int DW     = 16,
  parameter int CORE_N = 4,
  parameter int KSIZE  = 16,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DW*CORE_N-1:0]       x_din,
  input  logic                       x_din_valid,
  output logic                       x_wr_ready,
  input  logic                       wr_finish,
  output logic                       x_wr_drop,
  input  logic                       x_rd_en,
  input  logic [$clog2(DEPTH)-1:0]   x_rd_addr,
  input  logic                       rd_release,
  output logic                       x_rd_ready,
  output logic [$clog2(DEPTH):0]     x_rd_rows,
  output logic [DW*KSIZE-1:0]        x_dout,
  output logic                       x_dout_valid
);
  localparam int ITERA = KSIZE / CORE_N;
  localparam int AW    = $clog2(DEPTH);
  localparam int WW    = DW * CORE_N;
  localparam int MAXW  = DEPTH * ITERA;
  localparam int CW    = $clog2(MAXW + 1);
  localparam int LW    = (ITERA > 1) ? $clog2(ITERA) : 1;

  logic [WW-1:0]       mem_q [2][ITERA][DEPTH];
  logic                wsel_q, wsel_d, rsel_q, rsel_d;
  logic [1:0]          full_q, full_d;
  logic [CW-1:0]       cnt_q [2];
  logic [CW-1:0]       cnt_d [2];
  logic [CW-1:0]       wcnt_q, wcnt_d, wcnt_inc_s;
  logic                wr_ready_q, wr_ready_d, rd_ready_q, rd_ready_d;
  logic [AW:0]         rows_q, rows_d;
  logic                drop_q, dout_valid_q;
  logic [DW*KSIZE-1:0] dout_q, rd_row_s;
  logic                accept_s, commit_s, release_s, rd_fire_s;
  logic [LW-1:0]       wlane_s;
  logic [AW-1:0]       wrow_s;

  assign accept_s   = x_din_valid && wr_ready_q;
  assign wcnt_inc_s = wcnt_q + CW'(accept_s);
  assign commit_s   = wr_finish && (wcnt_inc_s != {CW{1'b0}});
  assign release_s  = rd_release && rd_ready_q;
  assign rd_fire_s  = x_rd_en && rd_ready_q;
  assign wlane_s    = LW'(wcnt_q % CW'(ITERA));
  assign wrow_s     = AW'(wcnt_q / CW'(ITERA));

  // Bank bookkeeping; a commit and a release always target different banks.
  always_comb begin
    full_d = full_q;
    cnt_d  = cnt_q;
    if (commit_s) begin
      full_d[wsel_q] = 1'b1;
      cnt_d[wsel_q]  = wcnt_inc_s;
      wsel_d         = ~wsel_q;
      wcnt_d         = {CW{1'b0}};
    end else begin
      wsel_d         = wsel_q;
      wcnt_d         = wcnt_inc_s;
    end
    if (release_s) begin
      full_d[rsel_q] = 1'b0;
      rsel_d         = ~rsel_q;
    end else begin
      rsel_d         = rsel_q;
    end
    wr_ready_d = !full_d[wsel_d] && (wcnt_d < CW'(MAXW));
    rd_ready_d = full_d[rsel_d];
    if (rd_ready_d) begin
      rows_d = (AW+1)'((32'(cnt_d[rsel_d]) + ITERA - 1) / ITERA);
    end else begin
      rows_d = {(AW+1){1'b0}};
    end
  end

  // Gather one row from all lanes of the read bank.
  always_comb begin
    rd_row_s = {(DW*KSIZE){1'b0}};
    for (int l = 0; l < ITERA; l++) begin
`ifdef MMU_XRAM_ZPAD_EN
      if ((32'(x_rd_addr) * ITERA + l) >= 32'(cnt_q[rsel_q])) begin
        rd_row_s[l*WW +: WW] = {WW{1'b0}};
      end else begin
        rd_row_s[l*WW +: WW] = mem_q[rsel_q][LW'(l)][x_rd_addr];
      end
`else
      rd_row_s[l*WW +: WW] = mem_q[rsel_q][LW'(l)][x_rd_addr];
`endif
    end
  end

  // Lane RAMs are never cleared.
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      mem_q[wsel_q][wlane_s][wrow_s] <= x_din;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wsel_q       <= 1'b0;
      rsel_q       <= 1'b0;
      full_q       <= 2'b00;
      cnt_q        <= '{default: '0};
      wcnt_q       <= {CW{1'b0}};
      wr_ready_q   <= 1'b0;
      rd_ready_q   <= 1'b0;
      rows_q       <= {(AW+1){1'b0}};
      drop_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_q       <= {(DW*KSIZE){1'b0}};
    end else begin
      wsel_q       <= wsel_d;
      rsel_q       <= rsel_d;
      full_q       <= full_d;
      cnt_q        <= cnt_d;
      wcnt_q       <= wcnt_d;
      wr_ready_q   <= wr_ready_d;
      rd_ready_q   <= rd_ready_d;
      rows_q       <= rows_d;
      drop_q       <= x_din_valid && !wr_ready_q;
      dout_valid_q <= rd_fire_s;
      if (rd_fire_s) begin
        dout_q <= rd_row_s;
      end
    end
  end

  assign x_wr_ready   = wr_ready_q;
  assign x_wr_drop    = drop_q;
  assign x_rd_ready   = rd_ready_q;
  assign x_rd_rows    = rows_q;
  assign x_dout       = dout_q;
  assign x_dout_valid = dout_valid_q;
endmodule

// File: tb/tb_mmu_xram_pp.sv
// Directed bench for mmu_xram_pp at default parameters; inputs change on negedge, outputs checked on negedge.
module tb_mmu_xram_pp;
  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  x_din;
  logic         x_din_valid, x_wr_ready, wr_finish, x_wr_drop;
  logic         x_rd_en, rd_release, x_rd_ready, x_dout_valid;
  logic [5:0]   x_rd_addr;
  logic [6:0]   x_rd_rows;
  logic [255:0] x_dout;
  int checks = 0;
  int errors = 0;

  mmu_xram_pp #(.DW(16), .CORE_N(4), .KSIZE(16), .DEPTH(64)) dut (
    .clk(clk), .rst(rst), .x_din(x_din), .x_din_valid(x_din_valid), .x_wr_ready(x_wr_ready),
    .wr_finish(wr_finish), .x_wr_drop(x_wr_drop), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
    .rd_release(rd_release), .x_rd_ready(x_rd_ready), .x_rd_rows(x_rd_rows),
    .x_dout(x_dout), .x_dout_valid(x_dout_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] wv(input int w);
    logic [15:0] e;
    e = 16'(w);
    return {e, e, e, e};
  endfunction

  function automatic logic [255:0] rowv(input int a, input int b, input int c, input int d);
    return {wv(d), wv(c), wv(b), wv(a)};
  endfunction

  task automatic idle();
    x_din = 64'd0; x_din_valid = 1'b0; wr_finish = 1'b0;
    x_rd_en = 1'b0; x_rd_addr = 6'd0; rd_release = 1'b0;
  endtask

  task automatic write_words(input int base, input int n, input bit fin);
    for (int i = 0; i < n; i++) begin
      x_din_valid = 1'b1; x_din = wv(base + i); wr_finish = fin && (i == n - 1);
      @(negedge clk);
    end
    x_din_valid = 1'b0; wr_finish = 1'b0;
  endtask

  task automatic read_row(input int addr);
    x_rd_en = 1'b1; x_rd_addr = 6'(addr);
    @(negedge clk);
    x_rd_en = 1'b0;
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    @(negedge clk);
    rd_release = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    repeat (2) @(negedge clk);
    checks++; if (x_wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready: got %b expected 0", x_wr_ready); end
    checks++; if (x_wr_drop !== 1'b0) begin errors++; $display("FAIL rst_drop: got %b expected 0", x_wr_drop); end
    checks++; if (x_rd_ready !== 1'b0) begin errors++; $display("FAIL rst_rd_ready: got %b expected 0", x_rd_ready); end
    checks++; if (x_rd_rows !== 7'd0) begin errors++; $display("FAIL rst_rows: got %0d expected 0", x_rd_rows); end
    checks++; if (x_dout !== 256'd0) begin errors++; $display("FAIL rst_dout: got %h expected 0", x_dout); end
    checks++; if (x_dout_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", x_dout_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (x_wr_ready !== 1'b1) begin errors++; $display("FAIL post_rst_wr_ready: got %b expected 1", x_wr_ready); end
    read_row(0);
    checks++; if (x_dout_valid !== 1'b0) begin errors++; $display("FAIL rd_not_ready_valid: got %b expected 0", x_dout_valid); end
  endtask

  task automatic test_full_tile();
    write_words(0, 64, 1'b1);
    checks++; if (x_rd_ready !== 1'b1) begin errors++; $display("FAIL tile_rd_ready: got %b expected 1", x_rd_ready); end
    checks++; if (x_rd_rows !== 7'd16) begin errors++; $display("FAIL tile_rows: got %0d expected 16", x_rd_rows); end
    checks++; if (x_wr_ready !== 1'b1) begin errors++; $display("FAIL tile_wr_ready_b1: got %b expected 1", x_wr_ready); end
    read_row(5);
    checks++; if (x_dout_valid !== 1'b1) begin errors++; $display("FAIL tile_valid: got %b expected 1", x_dout_valid); end
    checks++; if (x_dout !== rowv(20, 21, 22, 23)) begin errors++; $display("FAIL tile_row5: got %h expected %h", x_dout, rowv(20, 21, 22, 23)); end
    @(negedge clk);
    checks++; if (x_dout_valid !== 1'b0) begin errors++; $display("FAIL tile_valid_drop: got %b expected 0", x_dout_valid); end
    checks++; if (x_dout !== rowv(20, 21, 22, 23)) begin errors++; $display("FAIL tile_dout_hold: got %h expected %h", x_dout, rowv(20, 21, 22, 23)); end
    release_bank();
    checks++; if (x_rd_ready !== 1'b0) begin errors++; $display("FAIL tile_release_ready: got %b expected 0", x_rd_ready); end
    checks++; if (x_rd_rows !== 7'd0) begin errors++; $display("FAIL tile_release_rows: got %0d expected 0", x_rd_rows); end
  endtask

  task automatic test_fill_drop();
    write_words(1000, 256, 1'b0);
    checks++; if (x_wr_ready !== 1'b0) begin errors++; $display("FAIL fill_wr_ready: got %b expected 0", x_wr_ready); end
    checks++; if (x_wr_drop !== 1'b0) begin errors++; $display("FAIL fill_no_drop: got %b expected 0", x_wr_drop); end
    x_din_valid = 1'b1; x_din = wv(2000);
    @(negedge clk);
    x_din_valid = 1'b0;
    checks++; if (x_wr_drop !== 1'b1) begin errors++; $display("FAIL fill_drop_pulse: got %b expected 1", x_wr_drop); end
    @(negedge clk);
    checks++; if (x_wr_drop !== 1'b0) begin errors++; $display("FAIL fill_drop_once: got %b expected 0", x_wr_drop); end
    wr_finish = 1'b1;
    @(negedge clk);
    wr_finish = 1'b0;
    checks++; if (x_rd_rows !== 7'd64) begin errors++; $display("FAIL fill_rows: got %0d expected 64", x_rd_rows); end
    read_row(63);
    checks++; if (x_dout !== rowv(1252, 1253, 1254, 1255)) begin errors++; $display("FAIL fill_row63: got %h expected %h", x_dout, rowv(1252, 1253, 1254, 1255)); end
    release_bank();
  endtask

  task automatic test_ping_pong();
    write_words(200, 4, 1'b1);
    checks++; if (x_rd_rows !== 7'd1) begin errors++; $display("FAIL pp_b0_rows: got %0d expected 1", x_rd_rows); end
    for (int i = 0; i < 8; i++) begin
      x_din_valid = 1'b1; x_din = wv(300 + i); wr_finish = (i == 7);
      x_rd_en = 1'b1; x_rd_addr = 6'd0;
      @(negedge clk);
      checks++; if (x_dout_valid !== 1'b1 || x_dout !== rowv(200, 201, 202, 203)) begin
        errors++; $display("FAIL pp_read_b0[%0d]: got v=%b %h expected v=1 %h", i, x_dout_valid, x_dout, rowv(200, 201, 202, 203));
      end
    end
    idle();
    checks++; if (x_wr_ready !== 1'b0) begin errors++; $display("FAIL pp_both_full_wr_ready: got %b expected 0", x_wr_ready); end
    for (int i = 0; i < 8; i++) begin
      x_din_valid = 1'b1; x_din = wv(400 + i);
      @(negedge clk);
      checks++; if (x_wr_ready !== 1'b0 || x_wr_drop !== 1'b1) begin
        errors++; $display("FAIL pp_stall[%0d]: got ready=%b drop=%b expected ready=0 drop=1", i, x_wr_ready, x_wr_drop);
      end
    end
    x_din_valid = 1'b0;
    release_bank();
    checks++; if (x_rd_ready !== 1'b1) begin errors++; $display("FAIL pp_swap_ready: got %b expected 1", x_rd_ready); end
    checks++; if (x_rd_rows !== 7'd2) begin errors++; $display("FAIL pp_swap_rows: got %0d expected 2", x_rd_rows); end
    checks++; if (x_wr_ready !== 1'b1) begin errors++; $display("FAIL pp_b0_free: got %b expected 1", x_wr_ready); end
  endtask

  task automatic test_read_release_same();
    x_rd_en = 1'b1; x_rd_addr = 6'd1; rd_release = 1'b1;
    @(negedge clk);
    idle();
    checks++; if (x_dout !== rowv(304, 305, 306, 307)) begin errors++; $display("FAIL same_cycle_row: got %h expected %h", x_dout, rowv(304, 305, 306, 307)); end
    checks++; if (x_rd_ready !== 1'b0) begin errors++; $display("FAIL same_cycle_ready: got %b expected 0", x_rd_ready); end
    wr_finish = 1'b1;
    @(negedge clk);
    wr_finish = 1'b0;
    @(negedge clk);
    checks++; if (x_rd_ready !== 1'b0 || x_rd_rows !== 7'd0) begin
      errors++; $display("FAIL empty_finish: got ready=%b rows=%0d expected ready=0 rows=0", x_rd_ready, x_rd_rows);
    end
  endtask

  task automatic test_partial();
    write_words(100, 6, 1'b1);
    checks++; if (x_rd_rows !== 7'd2) begin errors++; $display("FAIL part_rows: got %0d expected 2", x_rd_rows); end
    read_row(0);
    checks++; if (x_dout !== rowv(100, 101, 102, 103)) begin errors++; $display("FAIL part_row0: got %h expected %h", x_dout, rowv(100, 101, 102, 103)); end
    read_row(1);
`ifdef MMU_XRAM_ZPAD_EN
    checks++; if (x_dout !== rowv(104, 105, 0, 0)) begin errors++; $display("FAIL part_row1: got %h expected %h", x_dout, rowv(104, 105, 0, 0)); end
    read_row(5);
    checks++; if (x_dout !== 256'd0) begin errors++; $display("FAIL part_row5: got %h expected 0", x_dout); end
`else
    checks++; if (x_dout !== rowv(104, 105, 6, 7)) begin errors++; $display("FAIL part_row1: got %h expected %h", x_dout, rowv(104, 105, 6, 7)); end
    read_row(5);
    checks++; if (x_dout !== rowv(20, 21, 22, 23)) begin errors++; $display("FAIL part_row5: got %h expected %h", x_dout, rowv(20, 21, 22, 23)); end
`endif
    release_bank();
  endtask

  task automatic test_reset_mid_tile();
    write_words(600, 10, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({x_wr_ready, x_wr_drop, x_rd_ready, x_dout_valid} !== 4'b0000 || x_rd_rows !== 7'd0 || x_dout !== 256'd0) begin
      errors++; $display("FAIL mid_rst_outputs: got wr=%b drop=%b rd=%b v=%b rows=%0d dout=%h expected all 0",
                        x_wr_ready, x_wr_drop, x_rd_ready, x_dout_valid, x_rd_rows, x_dout);
    end
    rst = 1'b0;
    @(negedge clk);
    write_words(500, 4, 1'b1);
    checks++; if (x_rd_ready !== 1'b1 || x_rd_rows !== 7'd1) begin
      errors++; $display("FAIL mid_rst_tile: got ready=%b rows=%0d expected ready=1 rows=1", x_rd_ready, x_rd_rows);
    end
    read_row(0);
    checks++; if (x_dout !== rowv(500, 501, 502, 503)) begin errors++; $display("FAIL mid_rst_row0: got %h expected %h", x_dout, rowv(500, 501, 502, 503)); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_full_tile();
    test_fill_drop();
    test_ping_pong();
    test_read_release_same();
    test_partial();
    test_reset_mid_tile();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
